taxi_xfcp_us_arb: RTL and testbench

- Frame-atomic round-robin arbiter that merges the upstream (response) byte streams of PORTS downstream XFCP ports onto the single upstream port of an XFCP switch.
- Once a port is granted, it holds the output until its frame's tlast beat is accepted; frames are never interleaved.
- One registered output stage.
- Sits between the downstream-port us interfaces and the upstream-port us interface, alongside the ds-direction routing logic.

---
 rtl/taxi_xfcp_us_arb.sv | 224 ++++++++++++++++++++++
 tb/tb_taxi_xfcp_us_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/taxi_xfcp_us_arb.sv
`default_nettype none
// ============================================================================
// Module   : taxi_xfcp_us_arb
// Purpose  : Frame-atomic round-robin arbiter merging the upstream (response)
//            byte streams of PORTS downstream XFCP ports onto the single
//            upstream port of an XFCP switch. A granted port owns the output
//            until its tlast beat is accepted. One registered output stage.
// Ports    : clk, rst_n (async active-low)
//            s_tdata/s_tvalid/s_tready/s_tlast/s_tuser : per-port inputs,
//                port i data in s_tdata[8*i+7:8*i]
//            m_tdata/m_tvalid/m_tready/m_tlast/m_tuser : merged output
//            grant : current / last granted port index
//            busy  : high while a frame is in progress
// Options  : TAXI_XFCP_ARB_TIMEOUT_EN - when defined, a granted port that
//            stalls mid-frame for TIMEOUT cycles gets its frame terminated
//            with a synthetic error beat (0x00, tlast=1, tuser=1) and the
//            remainder of its frame is discarded.
// Revision : 1.0 - initial release
// ============================================================================
module taxi_xfcp_us_arb #(
    parameter int PORTS   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [PORTS*8-1:0]                          s_tdata,
    input  logic [PORTS-1:0]                            s_tvalid,
    output logic [PORTS-1:0]                            s_tready,
    input  logic [PORTS-1:0]                            s_tlast,
    input  logic [PORTS-1:0]                            s_tuser,
    output logic [7:0]                                  m_tdata,
    output logic                                        m_tvalid,
    input  logic                                        m_tready,
    output logic                                        m_tlast,
    output logic                                        m_tuser,
    output logic [(PORTS > 1 ? $clog2(PORTS) : 1)-1:0]  grant,
    output logic                                        busy
);

    localparam int c_GW = (PORTS > 1) ? $clog2(PORTS) : 1;

    if (PORTS < 1 || PORTS > 16 || TIMEOUT < 1) begin : g_bad_param
        $error("taxi_xfcp_us_arb: PORTS must be 1..16 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1
`ifdef TAXI_XFCP_ARB_TIMEOUT_EN
        , ST_DROP = 2'd2
`endif
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [c_GW-1:0]   r_grant;
    logic [c_GW-1:0]   w_grant_next;
    logic              r_busy;
    logic              w_busy_next;

    logic [7:0]        r_m_tdata;
    logic              r_m_tvalid;
    logic              r_m_tlast;
    logic              r_m_tuser;

    logic [PORTS-1:0]  w_s_tready;
    logic              w_ready;
    logic              w_load;
    logic [7:0]        w_load_data;
    logic              w_load_last;
    logic              w_load_user;

    logic              w_req_any;
    logic [c_GW-1:0]   w_req_sel;

    logic              w_cur_valid;
    logic              w_cur_last;
    logic              w_cur_user;
    logic [7:0]        w_cur_data;

    // The output register can take a new beat when empty or draining.
    assign w_ready     = !r_m_tvalid || m_tready;

    assign w_cur_valid = s_tvalid[r_grant];
    assign w_cur_last  = s_tlast[r_grant];
    assign w_cur_user  = s_tuser[r_grant];
    assign w_cur_data  = s_tdata[{r_grant, 3'b000} +: 8];

    // Round-robin search starting one past the last grant. Iterating from
    // the farthest offset down lets the nearest requester overwrite the
    // selection, so the lowest offset from grant+1 wins.
    always_comb begin
        w_req_any = 1'b0;
        w_req_sel = r_grant;
        for (int i = PORTS; i >= 1; i--) begin
            if (s_tvalid[c_GW'((int'(r_grant) + i) % PORTS)]) begin
                w_req_any = 1'b1;
                w_req_sel = c_GW'((int'(r_grant) + i) % PORTS);
            end
        end
    end

`ifdef TAXI_XFCP_ARB_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT + 1);

    logic [c_TW-1:0]   r_to_cnt;
    logic              w_timed_out;

    assign w_timed_out = (r_to_cnt == c_TW'(TIMEOUT));

    // Counts stalled cycles of the granted port; saturates at TIMEOUT and
    // holds there until the terminator beat moves the FSM to DROP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state != ST_XFER) begin
            r_to_cnt <= '0;
        end else if (w_cur_valid && w_s_tready[r_grant]) begin
            r_to_cnt <= '0;
        end else if (!w_cur_valid && !w_timed_out) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_busy_next  = r_busy;
        w_s_tready   = '0;
        w_load       = 1'b0;
        w_load_data  = 8'h00;
        w_load_last  = 1'b0;
        w_load_user  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_req_any) begin
                    w_grant_next = w_req_sel;
                    w_busy_next  = 1'b1;
                    w_state_next = ST_XFER;
                end
            end

            ST_XFER: begin
`ifdef TAXI_XFCP_ARB_TIMEOUT_EN
                if (w_timed_out) begin
                    if (w_ready) begin
                        w_load       = 1'b1;
                        w_load_data  = 8'h00;
                        w_load_last  = 1'b1;
                        w_load_user  = 1'b1;
                        w_state_next = ST_DROP;
                    end
                end else begin
`endif
                    w_s_tready[r_grant] = w_ready;
                    if (w_cur_valid && w_ready) begin
                        w_load      = 1'b1;
                        w_load_data = w_cur_data;
                        w_load_last = w_cur_last;
                        w_load_user = w_cur_user;
                        if (w_cur_last) begin
                            w_state_next = ST_IDLE;
                            w_busy_next  = 1'b0;
                        end
                    end
`ifdef TAXI_XFCP_ARB_TIMEOUT_EN
                end
`endif
            end

`ifdef TAXI_XFCP_ARB_TIMEOUT_EN
            // Swallow the rest of the terminated frame without forwarding.
            ST_DROP: begin
                w_s_tready[r_grant] = 1'b1;
                if (w_cur_valid && w_cur_last) begin
                    w_state_next = ST_IDLE;
                    w_busy_next  = 1'b0;
                end
            end
`endif

            default: begin
                w_state_next = ST_IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= c_GW'(PORTS - 1);
            r_busy     <= 1'b0;
            r_m_tdata  <= 8'h00;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_busy  <= w_busy_next;
            if (w_load) begin
                r_m_tdata  <= w_load_data;
                r_m_tlast  <= w_load_last;
                r_m_tuser  <= w_load_user;
                r_m_tvalid <= 1'b1;
            end else if (m_tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    assign s_tready = w_s_tready;
    assign m_tdata  = r_m_tdata;
    assign m_tvalid = r_m_tvalid;
    assign m_tlast  = r_m_tlast;
    assign m_tuser  = r_m_tuser;
    assign grant    = r_grant;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_taxi_xfcp_us_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_taxi_xfcp_us_arb
// Purpose  : Self-checking bench for taxi_xfcp_us_arb (PORTS=4, TIMEOUT=8).
//            Per-cycle vector tables for the single-frame and backpressure
//            cases, hand-written sequences for mid-frame requests, reset,
//            round-robin ordering and (when enabled) the stall timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_taxi_xfcp_us_arb;

    localparam int PORTS   = 4;
    localparam int TIMEOUT = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [PORTS*8-1:0]  s_tdata = '0;
    logic [PORTS-1:0]    s_tvalid = '0;
    logic [PORTS-1:0]    s_tready;
    logic [PORTS-1:0]    s_tlast = '0;
    logic [PORTS-1:0]    s_tuser = '0;
    logic [7:0]          m_tdata;
    logic                m_tvalid;
    logic                m_tready = 1'b1;
    logic                m_tlast;
    logic                m_tuser;
    logic [1:0]          grant;
    logic                busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    taxi_xfcp_us_arb #(
        .PORTS   (PORTS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tlast  (s_tlast),
        .s_tuser  (s_tuser),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .m_tuser  (m_tuser),
        .grant    (grant),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One row = one clock cycle. s_tready is checked before the edge,
    // registered outputs just after it. m_* data fields are only checked
    // when exp_mvalid is set.
    typedef struct packed {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [3:0]  user;
        logic [31:0] data;
        logic        m_ready;
        logic [3:0]  exp_sready;
        logic        exp_mvalid;
        logic [7:0]  exp_mdata;
        logic        exp_mlast;
        logic        exp_muser;
        logic [1:0]  exp_grant;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[$];

    // round-robin model state
    int         pos[PORTS];
    int         nb;
    logic [7:0] got_d[16];
    logic       got_l[16];

    // timeout sequence state
    int         ph;
    int         sent;
    int         nb2;
    logic [9:0] beats[8];

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("reset m_tvalid", 32'(m_tvalid), 32'd0);
        check("reset m_tdata",  32'(m_tdata),  32'd0);
        check("reset m_tlast",  32'(m_tlast),  32'd0);
        check("reset m_tuser",  32'(m_tuser),  32'd0);
        check("reset s_tready", 32'(s_tready), 32'd0);
        check("reset grant",    32'(grant),    32'd3);
        check("reset busy",     32'(busy),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- vector tables ----------------
        // single frame on port 2: 0x11, 0x22 (tuser=1), 0x33 (tlast)
        vecs.push_back('{4'b0100, 4'b0000, 4'b0000, 32'h0011_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 2'd2, 1'b1});
        vecs.push_back('{4'b0100, 4'b0000, 4'b0000, 32'h0011_0000, 1'b1, 4'b0100, 1'b1, 8'h11, 1'b0, 1'b0, 2'd2, 1'b1});
        vecs.push_back('{4'b0100, 4'b0000, 4'b0100, 32'h0022_0000, 1'b1, 4'b0100, 1'b1, 8'h22, 1'b0, 1'b1, 2'd2, 1'b1});
        vecs.push_back('{4'b0100, 4'b0100, 4'b0000, 32'h0033_0000, 1'b1, 4'b0100, 1'b1, 8'h33, 1'b1, 1'b0, 2'd2, 1'b0});
        vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 2'd2, 1'b0});
        // 5-byte frame on port 1 with m_tready toggling; source holds until accepted
        vecs.push_back('{4'b0010, 4'b0000, 4'b0000, 32'h0000_A100, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 2'd1, 1'b1});
        vecs.push_back('{4'b0010, 4'b0000, 4'b0000, 32'h0000_A100, 1'b0, 4'b0010, 1'b1, 8'hA1, 1'b0, 1'b0, 2'd1, 1'b1});
        vecs.push_back('{4'b0010, 4'b0000, 4'b0000, 32'h0000_A200, 1'b1, 4'b0010, 1'b1, 8'hA2, 1'b0, 1'b0, 2'd1, 1'b1});
        vecs.push_back('{4'b0010, 4'b0000, 4'b0000, 32'h0000_A300, 1'b0, 4'b0000, 1'b1, 8'hA2, 1'b0, 1'b0, 2'd1, 1'b1});
        vecs.push_back('{4'b0010, 4'b0000, 4'b0000, 32'h0000_A300, 1'b1, 4'b0010, 1'b1, 8'hA3, 1'b0, 1'b0, 2'd1, 1'b1});
        vecs.push_back('{4'b0010, 4'b0000, 4'b0000, 32'h0000_A400, 1'b0, 4'b0000, 1'b1, 8'hA3, 1'b0, 1'b0, 2'd1, 1'b1});
        vecs.push_back('{4'b0010, 4'b0000, 4'b0000, 32'h0000_A400, 1'b1, 4'b0010, 1'b1, 8'hA4, 1'b0, 1'b0, 2'd1, 1'b1});
        vecs.push_back('{4'b0010, 4'b0010, 4'b0000, 32'h0000_A500, 1'b0, 4'b0000, 1'b1, 8'hA4, 1'b0, 1'b0, 2'd1, 1'b1});
        vecs.push_back('{4'b0010, 4'b0010, 4'b0000, 32'h0000_A500, 1'b1, 4'b0010, 1'b1, 8'hA5, 1'b1, 1'b0, 2'd1, 1'b0});
        vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b1, 8'hA5, 1'b1, 1'b0, 2'd1, 1'b0});
        vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 2'd1, 1'b0});

        foreach (vecs[k]) begin
            @(negedge clk);
            s_tvalid = vecs[k].valid;
            s_tlast  = vecs[k].last;
            s_tuser  = vecs[k].user;
            s_tdata  = vecs[k].data;
            m_tready = vecs[k].m_ready;
            #1;
            check($sformatf("vec%0d s_tready", k), 32'(s_tready), 32'(vecs[k].exp_sready));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d m_tvalid", k), 32'(m_tvalid), 32'(vecs[k].exp_mvalid));
            if (vecs[k].exp_mvalid) begin
                check($sformatf("vec%0d m_tdata", k), 32'(m_tdata), 32'(vecs[k].exp_mdata));
                check($sformatf("vec%0d m_tlast", k), 32'(m_tlast), 32'(vecs[k].exp_mlast));
                check($sformatf("vec%0d m_tuser", k), 32'(m_tuser), 32'(vecs[k].exp_muser));
            end
            check($sformatf("vec%0d grant", k), 32'(grant), 32'(vecs[k].exp_grant));
            check($sformatf("vec%0d busy", k),  32'(busy),  32'(vecs[k].exp_busy));
        end

        // ---------------- non-granted request mid-frame ----------------
        @(negedge clk);
        m_tready = 1'b1;
        s_tuser  = '0;
        s_tvalid = 4'b0010;
        s_tlast  = 4'b0000;
        s_tdata  = 32'h0000_B100;
        @(posedge clk);
        #1;
        check("midframe grant1", 32'(grant), 32'd1);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            s_tvalid = 4'b1010;
            s_tdata  = {8'hD1, 8'h00, 8'(8'hB1 + b), 8'h00};
            s_tlast  = (b == 2) ? 4'b1010 : 4'b1000;
            #1;
            check($sformatf("midframe s_tready b%0d", b), 32'(s_tready), 32'h2);
            @(posedge clk);
            #1;
            check($sformatf("midframe m_tvalid b%0d", b), 32'(m_tvalid), 32'd1);
            check($sformatf("midframe m_tdata b%0d", b),  32'(m_tdata),  32'(8'(8'hB1 + b)));
        end
        @(negedge clk);
        s_tvalid = 4'b1000;
        s_tlast  = 4'b1000;
        s_tdata  = 32'hD100_0000;
        #1;
        check("arb cycle s_tready", 32'(s_tready), 32'd0);
        @(posedge clk);
        #1;
        check("port3 grant", 32'(grant), 32'd3);
        check("port3 busy",  32'(busy),  32'd1);
        @(negedge clk);
        #1;
        check("port3 s_tready", 32'(s_tready), 32'h8);
        @(posedge clk);
        #1;
        check("port3 m_tdata", 32'(m_tdata), 32'hD1);
        check("port3 m_tlast", 32'(m_tlast), 32'd1);
        @(negedge clk);
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;

        // ---------------- reset mid-frame ----------------
        @(negedge clk);
        s_tvalid = 4'b0100;
        s_tdata  = 32'h00E1_0000;
        @(posedge clk);          // arbitration
        @(posedge clk);          // E1 accepted
        #1;
        check("prereset m_tdata", 32'(m_tdata), 32'hE1);
        @(negedge clk);
        s_tdata = 32'h00E2_0000;
        rst_n   = 1'b0;
        #1;
        check("midreset m_tvalid", 32'(m_tvalid), 32'd0);
        check("midreset s_tready", 32'(s_tready), 32'd0);
        check("midreset busy",     32'(busy),     32'd0);
        check("midreset grant",    32'(grant),    32'd3);
        @(negedge clk);
        s_tvalid = '0;
        s_tdata  = '0;
        rst_n    = 1'b1;

        // ---------------- round robin: 4 ports x 2 frames x 2 bytes ----------------
        for (int p = 0; p < PORTS; p++) pos[p] = 0;
        nb = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            for (int p = 0; p < PORTS; p++) begin
                s_tvalid[p]         = (pos[p] < 4);
                s_tdata[p*8 +: 8]   = 8'(p * 16 + pos[p]);
                s_tlast[p]          = (pos[p] % 2 == 1);
            end
            #1;
            if (m_tvalid && m_tready) begin
                if (nb < 16) begin
                    got_d[nb] = m_tdata;
                    got_l[nb] = m_tlast;
                end
                nb++;
            end
            for (int p = 0; p < PORTS; p++)
                if (s_tvalid[p] && s_tready[p]) pos[p]++;
            @(posedge clk);
        end
        check("rr beat count", 32'(nb), 32'd16);
        for (int k = 0; k < 16 && k < nb; k++) begin
            check($sformatf("rr beat%0d data", k), 32'(got_d[k]),
                  32'(((k / 2) % 4) * 16 + (k / 8) * 2 + (k % 2)));
            check($sformatf("rr beat%0d last", k), 32'(got_l[k]), 32'(k % 2));
        end

`ifdef TAXI_XFCP_ARB_TIMEOUT_EN
        // ---------------- stall timeout on port 0 ----------------
        ph   = 0;
        sent = 0;
        nb2  = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            s_tuser = '0;
            case (ph)
                0: begin s_tvalid = 4'b0001; s_tdata = 32'h5A; s_tlast = 4'b0000; end
                2: begin
                    s_tvalid = 4'b0001;
                    s_tdata  = (sent == 0) ? 32'h5B : 32'h5C;
                    s_tlast  = (sent == 1) ? 4'b0001 : 4'b0000;
                end
                default: begin s_tvalid = '0; s_tdata = '0; s_tlast = '0; end
            endcase
            #1;
            if (m_tvalid && m_tready) begin
                if (nb2 < 8) beats[nb2] = {m_tuser, m_tlast, m_tdata};
                nb2++;
            end
            if (s_tvalid[0] && s_tready[0]) begin
                if (ph == 0) ph = 1;
                else if (ph == 2) begin
                    sent++;
                    if (sent == 2) ph = 3;
                end
            end
            if (ph == 1 && nb2 >= 2) ph = 2;
            @(posedge clk);
        end
        #1;
        check("timeout drop done",  32'(ph),  32'd3);
        check("timeout beat count", 32'(nb2), 32'd2);
        check("timeout first beat", 32'(beats[0]), 32'h05A);
        check("timeout terminator", 32'(beats[1]), 32'h300);
        check("timeout busy",       32'(busy), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
